// File: rtl/wide_div_pkg.sv
// Shared types for the iterative wide divider.
package wide_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/wide_div.sv
// Iterative restoring divider: sign-magnitude operands, one quotient bit per
// cycle, with a two-cycle sign fix-up before the result is presented.
module wide_div
  import wide_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH    = 34,
  parameter int DIVIDEND_UNSIGNED = 1,
  parameter int DIVISOR_WIDTH     = 24,
  parameter int DIVISOR_UNSIGNED  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW + 1);

  if ((DIVIDEND_UNSIGNED != 0 && DIVIDEND_UNSIGNED != 1) ||
      (DIVISOR_UNSIGNED  != 0 && DIVISOR_UNSIGNED  != 1) ||
      DW < 2 || VW < 2) begin : g_param_err
    $error("wide_div: *_UNSIGNED must be 0 or 1 and widths must be >= 2");
  end

  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q, dvs_q, dvd_lo_q;
  logic          qneg_q, rneg_q, dbz_q, fix_q;

  // Operand conditioning: an unsigned operand is treated as a zero-extended
  // non-negative value, so only signed operands can contribute a sign.
  logic          dvd_neg, dvs_neg, accept;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag, dvd_lo;

  assign dvd_neg = (DIVIDEND_UNSIGNED == 0) && dividend[DW-1];
  assign dvs_neg = (DIVISOR_UNSIGNED == 0) && divisor[VW-1];
  assign dvd_mag = dvd_neg ? (~dividend + DW'(1)) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + VW'(1)) : divisor;

  // Dividend truncated (or extended by its own signedness) to divisor width,
  // returned as the remainder on divide-by-zero.
  if (DW >= VW) begin : g_lo_trunc
    assign dvd_lo = dividend[VW-1:0];
  end else begin : g_lo_ext
    assign dvd_lo = {{(VW-DW){dvd_neg}}, dividend};
  end

  assign s_ready = rst_n && (state_q == IDLE);
  assign m_valid = (state_q == DONE);
  assign accept  = s_valid && s_ready;

  // Restoring step: the partial remainder is always below the divisor
  // magnitude, so VW bits hold it and the trial needs only one extra bit.
  logic [VW:0]   trial, diff;
  logic          q_bit;
  logic [VW-1:0] rem_nxt;

  always_comb begin
    trial   = {rem_q, quo_q[DW-1]};
    diff    = trial - {1'b0, dvs_q};
    q_bit   = (trial >= {1'b0, dvs_q});
    rem_nxt = q_bit ? diff[VW-1:0] : trial[VW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (cnt_q == CW'(DW - 1)) state_d = FIX;
      FIX:  if (fix_q) state_d = DONE;
      DONE: if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dvd_lo_q    <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      fix_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          quo_q    <= dvd_mag;
          dvs_q    <= dvs_mag;
          rem_q    <= '0;
          cnt_q    <= '0;
          qneg_q   <= dvd_neg ^ dvs_neg;
          rneg_q   <= dvd_neg;
          dbz_q    <= (divisor == '0);
          dvd_lo_q <= dvd_lo;
          fix_q    <= 1'b0;
        end
        CALC: begin
          quo_q <= {quo_q[DW-2:0], q_bit};
          rem_q <= rem_nxt;
          cnt_q <= (cnt_q == CW'(DW - 1)) ? '0 : cnt_q + CW'(1);
        end
        // First fix cycle corrects the quotient sign, second one publishes.
        FIX: if (!fix_q) begin
          fix_q <= 1'b1;
          if (qneg_q) quo_q <= ~quo_q + DW'(1);
        end else begin
          fix_q       <= 1'b0;
          quotient    <= dbz_q ? '1 : quo_q;
          remainder   <= dbz_q ? dvd_lo_q : (rneg_q ? (~rem_q + VW'(1)) : rem_q);
          div_by_zero <= dbz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wide_div.md
WIDE_DIV -- requirements
Module: wide_div

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 34, the dividend and quotient width in bits.
REQ-002 SHALL have parameter DIVIDEND_UNSIGNED, default 1, where 1 means unsigned and 0 means two's-complement signed.
REQ-003 SHALL have parameter DIVISOR_WIDTH, default 24, the divisor and remainder width in bits.
REQ-004 SHALL have parameter DIVISOR_UNSIGNED, default 1, where 1 means unsigned and 0 means signed.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port s_valid, input, 1 bit: operand pair valid.
REQ-008 SHALL have port s_ready, output, 1 bit: divider can accept an operand pair.
REQ-009 SHALL have port dividend, input, DIVIDEND_WIDTH bits.
REQ-010 SHALL have port divisor, input, DIVISOR_WIDTH bits.
REQ-011 SHALL have port m_valid, output, 1 bit: result valid.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port quotient, output, DIVIDEND_WIDTH bits.
REQ-014 SHALL have port remainder, output, DIVISOR_WIDTH bits.
REQ-015 SHALL have port div_by_zero, output, 1 bit: qualified by m_valid.

Function
REQ-016 SHALL treat the result as signed when either parameter selects signed, and as unsigned otherwise.
REQ-017 SHALL zero-extend each unsigned operand by one bit internally before signed processing.
REQ-018 SHALL implement a state machine with states IDLE, CALC, FIX and DONE.
REQ-019 SHALL drive s_ready=1 only in IDLE.
REQ-020 SHALL move IDLE->CALC on an edge with s_valid&&s_ready, registering the operand magnitudes, the operand signs and the zero-divisor status.
REQ-021 SHALL perform one restoring shift-subtract step per cycle in CALC for exactly DIVIDEND_WIDTH cycles, tracked by an iteration counter, then move to FIX.
REQ-022 SHALL in FIX negate the quotient when the operand signs differ, give the remainder the dividend's sign, then move to DONE.
REQ-023 SHALL drive m_valid=1 only in DONE; accept = edge 0 gives m_valid=1 after edge DIVIDEND_WIDTH+2, a fixed latency independent of operand values.
REQ-024 SHALL hold quotient, remainder and div_by_zero stable while m_valid=1 && m_ready=0.
REQ-025 SHALL move DONE->IDLE on an edge with m_valid&&m_ready; the next operand pair can be accepted no earlier than the following edge.
REQ-026 SHALL on divisor==0 produce quotient=all ones, remainder=dividend truncated to DIVISOR_WIDTH and div_by_zero=1, with the same latency.
REQ-027 SHALL in signed mode truncate the quotient toward zero and satisfy quotient*divisor+remainder==dividend.
REQ-028 SHALL on signed min-dividend / -1 produce quotient=min value (wrapped), remainder=0 and div_by_zero=0.
REQ-029 SHALL ignore s_valid outside IDLE and drop no operands.

Reset
REQ-030 SHALL on rst_n=0 force state=IDLE, s_ready=0 while rst_n=0, m_valid=0, quotient=0, remainder=0, div_by_zero=0 and counter=0, immediately without a clock.
REQ-031 SHALL on reset assertion mid-CALC or mid-DONE abandon the operation and produce no result after release.
REQ-032 SHALL drive s_ready=1 on the first cycle after rst_n deasserts.

Structure
REQ-033 SHALL place the state enum typedef in the shared package wide_div_pkg.
REQ-034 SHALL be a single module with no sub-modules, because the datapath is one shift-subtract register set.
REQ-035 SHALL report an elaboration error when a *_UNSIGNED parameter is not 0 or 1, or a width is below 2.

Verification
REQ-036 SHALL cover unsigned defaults: 1000/7 -> quotient 142, remainder 6, m_valid after edge 36.
REQ-037 SHALL cover both inputs signed, 8/8 widths: -7/2 -> quotient -3, remainder -1; 7/-2 -> quotient -3, remainder 1.
REQ-038 SHALL cover 5/0 -> quotient all ones, remainder 5, div_by_zero=1.
REQ-039 SHALL cover signed 8-bit -128/-1 -> quotient -128, remainder 0.
REQ-040 SHALL cover holding m_ready=0 for 10 cycles -> outputs stable, s_ready=0, and a second s_valid is not accepted until after the handshake.
REQ-041 SHALL cover rst_n pulsed low mid-CALC -> m_valid never rises, s_ready=1 after release, and the next division is correct.
